// File: rtl/gte_mac_accum.sv
// GTE MAC accumulator: per-lane 44-bit accumulation of signed products seeded from a base vector,
// with sf shift, lm-dependent IR saturation and sticky MAC overflow flags on registered outputs.
module gte_mac_accum #(
    parameter int PROD_W     = 35,
    parameter int ACC_W      = 44,
    parameter int BASE_SHIFT = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic                 i_first,
    input  logic                 i_last,
    input  logic                 i_sf,
    input  logic                 i_lm,
    input  logic [PROD_W-1:0]    i_prod0,
    input  logic [PROD_W-1:0]    i_prod1,
    input  logic [PROD_W-1:0]    i_prod2,
    input  logic [31:0]          i_base0,
    input  logic [31:0]          i_base1,
    input  logic [31:0]          i_base2,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [31:0]          o_mac0,
    output logic [31:0]          o_mac1,
    output logic [31:0]          o_mac2,
    output logic [15:0]          o_ir0,
    output logic [15:0]          o_ir1,
    output logic [15:0]          o_ir2,
    output logic [8:0]           o_flags
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc_q   [3];
    logic [2:0]        pos_q;
    logic [2:0]        neg_q;
    logic [31:0]       mac_q   [3];
    logic [15:0]       ir_q    [3];
    logic [8:0]        flags_q;
    logic              valid_q;

    logic [PROD_W-1:0] prod    [3];
    logic [31:0]       base    [3];
    logic [ACC_W-1:0]  acc_new [3];
    logic [2:0]        pos_new;
    logic [2:0]        neg_new;
    logic [31:0]       mac_new [3];
    logic [15:0]       ir_new  [3];
    logic [2:0]        sat_new;
    logic              take;
    logic              finish;

    assign prod[0] = i_prod0;
    assign prod[1] = i_prod1;
    assign prod[2] = i_prod2;
    assign base[0] = i_base0;
    assign base[1] = i_base1;
    assign base[2] = i_base2;

    // Non-first steps are only meaningful inside an operation.
    assign take   = i_valid && (i_first || state == ACCUM);
    assign finish = take && i_last;

    always_comb begin
        logic [ACC_W-1:0]    src;
        logic [ACC_W:0]      sum;
        logic signed [31:0]  m;
        logic signed [31:0]  lo;
        pos_new = '0;
        neg_new = '0;
        sat_new = '0;
        lo      = i_lm ? 32'sd0 : -32'sd32768;
        for (int unsigned n = 0; n < 3; n++) begin
            src = i_first ? ({{(ACC_W-32){base[n][31]}}, base[n]} << BASE_SHIFT) : acc_q[n];
            sum = {src[ACC_W-1], src} + {{(ACC_W+1-PROD_W){prod[n][PROD_W-1]}}, prod[n]};
            pos_new[n] = !sum[ACC_W] &&  sum[ACC_W-1];
            neg_new[n] =  sum[ACC_W] && !sum[ACC_W-1];
            acc_new[n] = sum[ACC_W-1:0];
            mac_new[n] = i_sf ? acc_new[n][12 +: 32] : acc_new[n][31:0];
            m = $signed(mac_new[n]);
            if (m > 32'sd32767) begin
                ir_new[n]  = 16'h7FFF;
                sat_new[n] = 1'b1;
            end else if (m < lo) begin
                ir_new[n]  = lo[15:0];
                sat_new[n] = 1'b1;
            end else begin
                ir_new[n]  = m[15:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            pos_q   <= '0;
            neg_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
            for (int unsigned n = 0; n < 3; n++) begin
                acc_q[n] <= '0;
                mac_q[n] <= '0;
                ir_q[n]  <= '0;
            end
        end else begin
            valid_q <= finish;
            if (take) begin
                for (int unsigned n = 0; n < 3; n++) acc_q[n] <= acc_new[n];
                pos_q <= (i_first ? 3'b000 : pos_q) | pos_new;
                neg_q <= (i_first ? 3'b000 : neg_q) | neg_new;
                state <= i_last ? IDLE : ACCUM;
            end
            // Results are formed from this step's sum so o_valid lands one cycle after i_last.
            if (finish) begin
                for (int unsigned n = 0; n < 3; n++) begin
                    mac_q[n] <= mac_new[n];
                    ir_q[n]  <= ir_new[n];
                end
                flags_q <= {sat_new,
                            (i_first ? 3'b000 : neg_q) | neg_new,
                            (i_first ? 3'b000 : pos_q) | pos_new};
            end
        end
    end

    assign o_busy  = (state == ACCUM);
    assign o_valid = valid_q;
    assign o_mac0  = mac_q[0];
    assign o_mac1  = mac_q[1];
    assign o_mac2  = mac_q[2];
    assign o_ir0   = ir_q[0];
    assign o_ir1   = ir_q[1];
    assign o_ir2   = ir_q[2];
    assign o_flags = flags_q;

endmodule

// File: tb/tb_gte_mac_accum.sv
// Directed self-checking bench for gte_mac_accum with hand-computed expected results.
module tb_gte_mac_accum;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0, i_first = 1'b0, i_last = 1'b0, i_sf = 1'b0, i_lm = 1'b0;
    logic [34:0] i_prod0 = '0, i_prod1 = '0, i_prod2 = '0;
    logic [31:0] i_base0 = '0, i_base1 = '0, i_base2 = '0;
    logic        o_busy, o_valid;
    logic [31:0] o_mac0, o_mac1, o_mac2;
    logic [15:0] o_ir0, o_ir1, o_ir2;
    logic [8:0]  o_flags;

    int checks = 0;
    int failures = 0;

    gte_mac_accum #(.PROD_W(35), .ACC_W(44), .BASE_SHIFT(12)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
        .i_sf(i_sf), .i_lm(i_lm),
        .i_prod0(i_prod0), .i_prod1(i_prod1), .i_prod2(i_prod2),
        .i_base0(i_base0), .i_base1(i_base1), .i_base2(i_base2),
        .o_busy(o_busy), .o_valid(o_valid),
        .o_mac0(o_mac0), .o_mac1(o_mac1), .o_mac2(o_mac2),
        .o_ir0(o_ir0), .o_ir1(o_ir1), .o_ir2(o_ir2), .o_flags(o_flags)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
    task automatic step(input logic v, input logic f, input logic l, input logic sf, input logic lm,
                        input logic [34:0] p0, input logic [34:0] p1, input logic [34:0] p2,
                        input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
        @(negedge i_clk);
        i_valid = v; i_first = f; i_last = l; i_sf = sf; i_lm = lm;
        i_prod0 = p0; i_prod1 = p1; i_prod2 = p2;
        i_base0 = b0; i_base1 = b1; i_base2 = b2;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        // Reset
        idle();
        idle();
        check("rst_busy", o_busy, 0);
        check("rst_valid", o_valid, 0);
        check("rst_mac0", o_mac0, 0);
        check("rst_mac2", o_mac2, 0);
        check("rst_ir1", o_ir1, 0);
        check("rst_flags", o_flags, 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Last-only step in IDLE is ignored
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 35'd77, '0, '0, '0, '0, '0);
        check("idle_last_valid", o_valid, 0);
        check("idle_last_busy", o_busy, 0);

        // Three steps of 4096*4096, sf=1
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 35'd16777216, '0, '0, '0, '0, '0);
        check("t1_busy_a", o_busy, 1);
        check("t1_valid_a", o_valid, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 35'd16777216, '0, '0, '0, '0, '0);
        check("t1_busy_b", o_busy, 1);
        check("t1_valid_b", o_valid, 0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 35'd16777216, '0, '0, '0, '0, '0);
        check("t1_valid", o_valid, 1);
        check("t1_busy_end", o_busy, 0);
        check("t1_mac0", o_mac0, 32'd12288);
        check("t1_ir0", o_ir0, 16'd12288);
        check("t1_flags", o_flags, 9'h000);
        idle();
        check("t1_pulse_end", o_valid, 0);
        check("t1_mac0_hold", o_mac0, 32'd12288);

        // Single step, lane1: (10<<12)+256, IR saturates high
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 35'h100, '0, '0, 32'd10, '0);
        check("t2_valid", o_valid, 1);
        check("t2_busy", o_busy, 0);
        check("t2_mac1", o_mac1, 32'd41216);
        check("t2_ir1", o_ir1, 16'h7FFF);
        check("t2_flags", o_flags, 9'h080);
        check("t2_mac0", o_mac0, 32'd0);

        // lm=1: negative value clamps to 0
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -35'sd5, '0, '0, '0, '0, '0);
        check("t3_valid", o_valid, 1);
        check("t3_mac0", o_mac0, 32'hFFFF_FFFB);
        check("t3_ir0", o_ir0, 16'h0000);
        check("t3_flags", o_flags, 9'h040);

        // Positive overflow on lane2, result wraps
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, 32'h7FFF_FFFF);
        check("t4_busy", o_busy, 1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 35'd8192, '0, '0, '0);
        check("t4_valid", o_valid, 1);
        check("t4_mac2", o_mac2, 32'h8000_0001);
        check("t4_ir2", o_ir2, 16'h8000);
        check("t4_flags", o_flags, 9'h104);

        // Back-to-back first, then stall and abort
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 35'd999, '0, 35'd5, '0, '0, 32'd3);
        check("t5_valid_a", o_valid, 0);
        check("t5_busy_a", o_busy, 1);
        check("t5_mac2_hold", o_mac2, 32'h8000_0001);
        check("t5_flags_hold", o_flags, 9'h104);
        idle();
        check("t5_stall1_busy", o_busy, 1);
        check("t5_stall1_valid", o_valid, 0);
        idle();
        check("t5_stall2_busy", o_busy, 1);
        check("t5_stall2_valid", o_valid, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 35'd4096, '0, '0, '0, '0, '0);
        check("t5_restart_busy", o_busy, 1);
        check("t5_restart_valid", o_valid, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 35'd4096, '0, '0, '0, '0, '0);
        check("t5_valid", o_valid, 1);
        check("t5_mac0", o_mac0, 32'd8192);
        check("t5_ir0", o_ir0, 16'd8192);
        check("t5_mac2", o_mac2, 32'd0);
        check("t5_flags", o_flags, 9'h000);
        idle();
        check("t5_single_pulse", o_valid, 0);

        // Reset mid-operation
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 35'd100, '0, '0, '0, '0, '0);
        check("t6_busy_pre", o_busy, 1);
        @(negedge i_clk);
        i_rst = 1'b1;
        idle();
        check("t6_busy", o_busy, 0);
        check("t6_valid", o_valid, 0);
        check("t6_mac0", o_mac0, 0);
        check("t6_ir0", o_ir0, 0);
        check("t6_flags", o_flags, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 35'd100, '0, '0, '0, '0, '0);
        check("t6_last_ignored", o_valid, 0);
        check("t6_mac0_after", o_mac0, 0);
        idle();
        check("t6_valid_after", o_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
